// File: rtl/cnn_stream_pkg.sv
// Shared types and default geometry for the CNN pixel-stream pipeline.
// The streamer and the convolution window agree on beat layout through this package.
package cnn_stream_pkg;

    localparam int DEF_WORD_SIZE = 8;
    localparam int DEF_ROW_SIZE  = 540;
    localparam int DEF_NUM_ROWS  = 540;

    typedef struct packed {
        logic [DEF_WORD_SIZE-1:0] data;
        logic                     sof;
        logic                     eol;
        logic                     eof;
    } pixel_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } streamer_state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry beat FIFO between the RAM return path and the output handshake.
// The producer never pushes when full, so no overflow guard is needed here.
module stream_skid_fifo
    import cnn_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  pixel_beat_t push_beat,
    input  logic        pop,
    output pixel_beat_t head,
    output logic [1:0]  count
);

    pixel_beat_t mem_q [2];
    pixel_beat_t mem_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_beat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pixel_streamer.sv
// Reads one frame from a sync-read pixel RAM in raster order and streams it
// out with sof/eol/eof markers, optionally wrapped in a 1-pixel zero border.
module pixel_streamer
    import cnn_stream_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int ROW_SIZE   = DEF_ROW_SIZE,
    parameter int NUM_ROWS   = DEF_NUM_ROWS,
    parameter int PAD        = 1,
    parameter int ADDR_WIDTH = $clog2(ROW_SIZE*NUM_ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0]  mem_rd_data,
    output logic [WORD_SIZE-1:0]  out_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof
);

    localparam int W_OUT = ROW_SIZE + 2*PAD;
    localparam int H_OUT = NUM_ROWS + 2*PAD;
    localparam int CW    = $clog2(W_OUT + 1);
    localparam int RW    = $clog2(H_OUT + 1);

    localparam logic [CW-1:0] C_LAST = CW'(W_OUT - 1);
    localparam logic [CW-1:0] C_HI   = CW'(ROW_SIZE + PAD);
    localparam logic [RW-1:0] R_LAST = RW'(H_OUT - 1);
    localparam logic [RW-1:0] R_HI   = RW'(NUM_ROWS + PAD);

    streamer_state_e       state_q, state_d;
    logic [RW-1:0]         r_q, r_d;
    logic [CW-1:0]         c_q, c_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  pend_border_q, pend_border_d;
    logic [2:0]            pend_flags_q, pend_flags_d;

    logic                  idle_go;
    logic [RW-1:0]         cur_r;
    logic [CW-1:0]         cur_c;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [2:0]            occupancy;
    logic                  permit;
    logic                  issue;
    logic                  interior;
    logic                  last_col;
    logic                  last_pos;

    logic                  push;
    logic                  pop;
    pixel_beat_t           push_beat;
    pixel_beat_t           head;
    logic [1:0]            fifo_count;

    // Position (0,0) is issued in the start cycle itself so the first beat
    // lands on the second cycle after start is sampled.
    always_comb begin
        idle_go   = (state_q == IDLE) && start;
        cur_r     = idle_go ? '0 : r_q;
        cur_c     = idle_go ? '0 : c_q;
        cur_addr  = idle_go ? '0 : addr_q;
        occupancy = {1'b0, fifo_count} + {2'b00, pend_vld_q};
        permit    = occupancy < (3'd2 + {2'b00, pop});
        issue     = idle_go || ((state_q == STREAM) && permit);
        last_col  = (cur_c == C_LAST);
        last_pos  = last_col && (cur_r == R_LAST);
        interior  = (PAD == 0 || (cur_r != '0 && cur_c != '0))
                    && (cur_r < R_HI) && (cur_c < C_HI);
        mem_rd_en = issue && interior;
        mem_addr  = cur_addr;
    end

    always_comb begin
        state_d       = state_q;
        r_d           = r_q;
        c_d           = c_q;
        addr_d        = addr_q;
        done          = 1'b0;
        pend_vld_d    = issue;
        pend_border_d = !interior;
        pend_flags_d  = {(cur_r == '0) && (cur_c == '0), last_col, last_pos};
        unique case (state_q)
            IDLE: begin
                if (start) state_d = STREAM;
            end
            STREAM: begin
                state_d = STREAM;
            end
            DRAIN: begin
                if (fifo_count == 2'd0 && !pend_vld_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            addr_d = interior ? cur_addr + ADDR_WIDTH'(1) : cur_addr;
            if (last_col) begin
                c_d = '0;
                r_d = cur_r + RW'(1);
            end else begin
                c_d = cur_c + CW'(1);
                r_d = cur_r;
            end
            if (last_pos) state_d = DRAIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            r_q           <= '0;
            c_q           <= '0;
            addr_q        <= '0;
            pend_vld_q    <= 1'b0;
            pend_border_q <= 1'b0;
            pend_flags_q  <= 3'b000;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            c_q           <= c_d;
            addr_q        <= addr_d;
            pend_vld_q    <= pend_vld_d;
            pend_border_q <= pend_border_d;
            pend_flags_q  <= pend_flags_d;
        end
    end

    // Border slots ride the same 1-cycle delay as RAM reads to keep raster order.
    always_comb begin
        push           = pend_vld_q;
        push_beat.data = pend_border_q ? '0 : DEF_WORD_SIZE'(mem_rd_data);
        push_beat.sof  = pend_flags_q[2];
        push_beat.eol  = pend_flags_q[1];
        push_beat.eof  = pend_flags_q[0];
    end

    stream_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_pixel = out_valid ? WORD_SIZE'(head.data) : '0;
    assign out_sof   = out_valid && head.sof;
    assign out_eol   = out_valid && head.eol;
    assign out_eof   = out_valid && head.eof;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_streamer.sv
// Directed bench for pixel_streamer: a 4x3 frame streamed with and without
// border, under backpressure, ignored restarts and a mid-frame reset.
module tb_pixel_streamer;

    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic rdy = 1'b0;
    bit   sel = 1'b0;

    logic          busy0, done0, rd_en0, valid0, sof0, eol0, eof0;
    logic [AW-1:0] addr0;
    logic [7:0]    pix0;
    logic [7:0]    ram0;
    logic          busy1, done1, rd_en1, valid1, sof1, eol1, eof1;
    logic [AW-1:0] addr1;
    logic [7:0]    pix1;
    logic [7:0]    ram1;

    logic start0, start1, rdy0, rdy1;
    logic t_busy, t_done, t_rd_en, t_valid, t_sof, t_eol, t_eof;
    logic [7:0] t_pix;

    int checks = 0;
    int failures = 0;

    int n_beats, done_cnt, rd_cnt, done_cyc, first_v, hold_err, rd_at20;
    logic busy_at0, busy_after, v19, sof19;
    logic [7:0] pix19;
    logic [10:0] bbeat [64];

    always #5 clk = ~clk;

    assign start0 = start && !sel;
    assign start1 = start && sel;
    assign rdy0   = rdy && !sel;
    assign rdy1   = rdy && sel;

    assign t_busy  = sel ? busy1  : busy0;
    assign t_done  = sel ? done1  : done0;
    assign t_rd_en = sel ? rd_en1 : rd_en0;
    assign t_valid = sel ? valid1 : valid0;
    assign t_pix   = sel ? pix1   : pix0;
    assign t_sof   = sel ? sof1   : sof0;
    assign t_eol   = sel ? eol1   : eol0;
    assign t_eof   = sel ? eof1   : eof0;

    // RAM[i] = i for both instances
    always @(posedge clk) begin
        if (rd_en0) ram0 <= {4'b0000, addr0};
        if (rd_en1) ram1 <= {4'b0000, addr1};
    end

    pixel_streamer #(.WORD_SIZE(8), .ROW_SIZE(4), .NUM_ROWS(3), .PAD(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .mem_rd_en(rd_en0), .mem_addr(addr0), .mem_rd_data(ram0),
        .out_pixel(pix0), .out_valid(valid0), .out_ready(rdy0),
        .out_sof(sof0), .out_eol(eol0), .out_eof(eof0)
    );

    pixel_streamer #(.WORD_SIZE(8), .ROW_SIZE(4), .NUM_ROWS(3), .PAD(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .mem_rd_en(rd_en1), .mem_addr(addr1), .mem_rd_data(ram1),
        .out_pixel(pix1), .out_valid(valid1), .out_ready(rdy1),
        .out_sof(sof1), .out_eol(eol1), .out_eof(eof1)
    );

    // Pulses start, then runs up to budget cycles recording accepted beats.
    // mode 0: ready=1; mode 1: ready 1,0,0,1 repeating; mode 2: ready=0 for 20 cycles.
    task automatic collect(input int mode, input int budget, input int restart_at);
        bit   dseen;
        bit   rs_done;
        logic pv, pr;
        logic [10:0] pb;
        n_beats = 0; done_cnt = 0; rd_cnt = 0; done_cyc = -1; first_v = -1;
        hold_err = 0; rd_at20 = -1; busy_at0 = 1'bx; busy_after = 1'bx;
        v19 = 1'bx; sof19 = 1'bx; pix19 = 'x;
        for (int i = 0; i < 64; i++) bbeat[i] = 'x;
        dseen = 0; rs_done = 0; pv = 0; pr = 0; pb = '0;
        rdy = 1'b0;
        start = 1'b1;
        @(negedge clk);
        if (t_rd_en) rd_cnt++;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            case (mode)
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       rdy = (cyc >= 20);
                default: rdy = 1'b1;
            endcase
            if (restart_at >= 0 && n_beats == restart_at && !rs_done) begin
                start = 1'b1;
                rs_done = 1;
            end
            @(negedge clk);
            if (cyc == 0) busy_at0 = t_busy;
            if (dseen) begin
                busy_after = t_busy;
                break;
            end
            if (t_rd_en) rd_cnt++;
            if (cyc == 19) begin
                v19 = t_valid; pix19 = t_pix; sof19 = t_sof; rd_at20 = rd_cnt;
            end
            if (pv && !pr && (!t_valid || {t_pix, t_sof, t_eol, t_eof} !== pb))
                hold_err++;
            if (t_valid && first_v < 0) first_v = cyc;
            if (t_valid && rdy) begin
                if (n_beats < 64) bbeat[n_beats] = {t_pix, t_sof, t_eol, t_eof};
                n_beats++;
            end
            if (t_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                dseen = 1;
            end
            pv = t_valid; pr = rdy; pb = {t_pix, t_sof, t_eol, t_eof};
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #1;
        start = 1'b0;
        rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy0, done0, rd_en0, addr0, valid0, pix0, sof0, eol0, eof0} !== '0) begin
            failures++;
            $display("FAIL reset_outs_pad0 got=%h exp=0",
                {busy0, done0, rd_en0, addr0, valid0, pix0, sof0, eol0, eof0});
        end
        checks++;
        if ({busy1, done1, rd_en1, addr1, valid1, pix1, sof1, eol1, eof1} !== '0) begin
            failures++;
            $display("FAIL reset_outs_pad1 got=%h exp=0",
                {busy1, done1, rd_en1, addr1, valid1, pix1, sof1, eol1, eof1});
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy0, busy1, valid0, valid1} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=0000", {busy0, busy1, valid0, valid1});
        end
    endtask

    task automatic test_basic();
        logic [10:0] e;
        sel = 0;
        collect(0, 100, -1);
        checks++;
        if (n_beats !== 12) begin
            failures++; $display("FAIL basic_beats got=%0d exp=12", n_beats);
        end
        for (int i = 0; i < 12; i++) begin
            e = {8'(i), 1'(i == 0), 1'(i % 4 == 3), 1'(i == 11)};
            checks++;
            if (bbeat[i] !== e) begin
                failures++; $display("FAIL basic_beat%0d got=%h exp=%h", i, bbeat[i], e);
            end
        end
        checks++;
        if (busy_at0 !== 1'b1) begin
            failures++; $display("FAIL basic_busy_start got=%b exp=1", busy_at0);
        end
        checks++;
        if (first_v !== 1) begin
            failures++; $display("FAIL basic_latency got=%0d exp=1", first_v);
        end
        checks++;
        if (done_cyc !== 13 || done_cnt !== 1) begin
            failures++;
            $display("FAIL basic_done got=cyc%0d/n%0d exp=cyc13/n1", done_cyc, done_cnt);
        end
        checks++;
        if (busy_after !== 1'b0) begin
            failures++; $display("FAIL basic_busy_after got=%b exp=0", busy_after);
        end
        checks++;
        if (rd_cnt !== 12) begin
            failures++; $display("FAIL basic_reads got=%0d exp=12", rd_cnt);
        end
    endtask

    task automatic test_pad();
        logic [7:0] exp_pix [30];
        logic [10:0] e;
        exp_pix = '{8'd0, 8'd0, 8'd0, 8'd0,  8'd0,  8'd0,
                    8'd0, 8'd0, 8'd1, 8'd2,  8'd3,  8'd0,
                    8'd0, 8'd4, 8'd5, 8'd6,  8'd7,  8'd0,
                    8'd0, 8'd8, 8'd9, 8'd10, 8'd11, 8'd0,
                    8'd0, 8'd0, 8'd0, 8'd0,  8'd0,  8'd0};
        sel = 1;
        collect(0, 100, -1);
        checks++;
        if (n_beats !== 30) begin
            failures++; $display("FAIL pad_beats got=%0d exp=30", n_beats);
        end
        for (int i = 0; i < 30; i++) begin
            e = {exp_pix[i], 1'(i == 0), 1'(i % 6 == 5), 1'(i == 29)};
            checks++;
            if (bbeat[i] !== e) begin
                failures++; $display("FAIL pad_beat%0d got=%h exp=%h", i, bbeat[i], e);
            end
        end
        checks++;
        if (rd_cnt !== 12) begin
            failures++; $display("FAIL pad_reads got=%0d exp=12", rd_cnt);
        end
        checks++;
        if (done_cyc !== 31 || done_cnt !== 1 || busy_after !== 1'b0) begin
            failures++;
            $display("FAIL pad_done got=cyc%0d/n%0d/busy%b exp=cyc31/n1/busy0",
                done_cyc, done_cnt, busy_after);
        end
        sel = 0;
    endtask

    task automatic test_backpressure();
        logic [10:0] e;
        sel = 0;
        collect(1, 200, -1);
        checks++;
        if (n_beats !== 12) begin
            failures++; $display("FAIL bp_beats got=%0d exp=12", n_beats);
        end
        for (int i = 0; i < 12; i++) begin
            e = {8'(i), 1'(i == 0), 1'(i % 4 == 3), 1'(i == 11)};
            checks++;
            if (bbeat[i] !== e) begin
                failures++; $display("FAIL bp_beat%0d got=%h exp=%h", i, bbeat[i], e);
            end
        end
        checks++;
        if (hold_err !== 0) begin
            failures++; $display("FAIL bp_hold got=%0d exp=0", hold_err);
        end
        checks++;
        if (done_cnt !== 1 || rd_cnt !== 12) begin
            failures++;
            $display("FAIL bp_done_reads got=n%0d/r%0d exp=n1/r12", done_cnt, rd_cnt);
        end
    endtask

    task automatic test_stall();
        logic [10:0] e;
        sel = 0;
        collect(2, 200, -1);
        checks++;
        if (rd_at20 > 2 || rd_at20 < 1) begin
            failures++; $display("FAIL stall_reads got=%0d exp=1..2", rd_at20);
        end
        checks++;
        if ({v19, pix19, sof19} !== {1'b1, 8'd0, 1'b1}) begin
            failures++;
            $display("FAIL stall_head got=v%b/p%0d/s%b exp=v1/p0/s1", v19, pix19, sof19);
        end
        checks++;
        if (hold_err !== 0) begin
            failures++; $display("FAIL stall_hold got=%0d exp=0", hold_err);
        end
        checks++;
        if (n_beats !== 12 || done_cnt !== 1) begin
            failures++;
            $display("FAIL stall_frame got=b%0d/n%0d exp=b12/n1", n_beats, done_cnt);
        end
        for (int i = 0; i < 12; i++) begin
            e = {8'(i), 1'(i == 0), 1'(i % 4 == 3), 1'(i == 11)};
            checks++;
            if (bbeat[i] !== e) begin
                failures++; $display("FAIL stall_beat%0d got=%h exp=%h", i, bbeat[i], e);
            end
        end
    endtask

    task automatic test_restart_ignored();
        sel = 0;
        collect(0, 100, 5);
        checks++;
        if (n_beats !== 12) begin
            failures++; $display("FAIL restart_beats got=%0d exp=12", n_beats);
        end
        checks++;
        if (done_cnt !== 1 || rd_cnt !== 12) begin
            failures++;
            $display("FAIL restart_done_reads got=n%0d/r%0d exp=n1/r12", done_cnt, rd_cnt);
        end
        checks++;
        if (bbeat[11] !== {8'd11, 1'b0, 1'b1, 1'b1}) begin
            failures++; $display("FAIL restart_last got=%h exp=%h", bbeat[11], {8'd11, 3'b011});
        end
        checks++;
        if (busy_after !== 1'b0) begin
            failures++; $display("FAIL restart_busy_after got=%b exp=0", busy_after);
        end
    endtask

    task automatic test_reset_mid();
        int nb;
        logic [10:0] e;
        sel = 0; nb = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rdy = 1'b1;
        for (int cyc = 0; cyc < 40 && nb < 6; cyc++) begin
            @(negedge clk);
            if (valid0 && rdy) nb++;
            @(posedge clk); #1;
        end
        #1;
        checks++;
        if ({valid0, pix0, busy0} !== {1'b1, 8'd6, 1'b1}) begin
            failures++;
            $display("FAIL mid_pre_reset got=v%b/p%0d/b%b exp=v1/p6/b1", valid0, pix0, busy0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy0, done0, rd_en0, addr0, valid0, pix0, sof0, eol0, eof0} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outs got=%h exp=0",
                {busy0, done0, rd_en0, addr0, valid0, pix0, sof0, eol0, eof0});
        end
        rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        collect(0, 100, -1);
        checks++;
        if (n_beats !== 12 || done_cnt !== 1) begin
            failures++;
            $display("FAIL mid_frame got=b%0d/n%0d exp=b12/n1", n_beats, done_cnt);
        end
        for (int i = 0; i < 12; i++) begin
            e = {8'(i), 1'(i == 0), 1'(i % 4 == 3), 1'(i == 11)};
            checks++;
            if (bbeat[i] !== e) begin
                failures++; $display("FAIL mid_beat%0d got=%h exp=%h", i, bbeat[i], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pad();
        test_backpressure();
        test_stall();
        test_restart_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
